ysyx_041461_mem: RTL and testbench

Memory-access stage of the ysyx_041461 in-order RV64 pipeline. It sits between EXE and WB. It takes the effective address and store data from EXE and performs one bus transaction per load or store. It checks natural alignment, shifts store data and builds byte masks, and aligns and sign- or zero-extends load data. It then presents the result, trap code and `MEM_ok` completion flag to WB, and holds the stage until WB accepts.

---
 rtl/ysyx_041461_mem.sv | 179 +++++++++++++++++
 tb/tb_ysyx_041461_mem.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_mem.sv
// rtl/ysyx_041461_mem.sv - RV64 pipeline memory-access stage (EXE -> bus -> WB)
//
// Optional feature macro: YSYX_041461_MEM_ACK_BYPASS_EN
//   defined   : the ack cycle completes the stage combinationally when WB is ready
//   undefined : every access passes through DONE; outputs are registered only
//
// Ports
//   clk, rst                         stage clock, synchronous active-high reset
//   MEM_valid/rd_en/wr_en            instruction presence and load/store kind
//   MEM_size/unsigned                access size (0 B, 1 H, 2 W, 3 D) and zero-extend select
//   MEM_addr/wdata                   effective address and right-aligned store data
//   MEM_trap_in                      trap code raised upstream
//   WB_ready                         WB accepts the result this cycle
//   mem_req/we/addr/wdata/wmask      bus request fields, held stable while mem_req=1
//   mem_ack/rdata                    bus completion and aligned doubleword read data
//   MEM_result/trap/ok/ready         result, trap code, completion and accept to the pipeline
module ysyx_041461_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    input  logic [1:0]  MEM_size,
    input  logic        MEM_unsigned,
    input  logic [63:0] MEM_addr,
    input  logic [63:0] MEM_wdata,
    input  logic [3:0]  MEM_trap_in,
    input  logic        WB_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [63:0] MEM_result,
    output logic [3:0]  MEM_trap,
    output logic        MEM_ok,
    output logic        MEM_ready
);

    localparam logic [3:0] ysyx_041461_TRAP_NOP           = 4'd0;
    localparam logic [3:0] ysyx_041461_MEM_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] ysyx_041461_MEM_STORE_MISALIGN = 4'd6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [2:0]  off_q;
    logic [63:0] result_q;

    logic        aligned;
    logic        access;
    logic [7:0]  base_mask;
    logic [63:0] raw;
    logic [63:0] load_ext;

    always_comb begin
        aligned = 1'b1;
        case (MEM_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~MEM_addr[0];
            2'd2:    aligned = (MEM_addr[1:0] == 2'd0);
            default: aligned = (MEM_addr[2:0] == 3'd0);
        endcase
    end

    // Upstream traps win; misalignment is only reported for real memory ops.
    always_comb begin
        MEM_trap = ysyx_041461_TRAP_NOP;
        if (MEM_trap_in != ysyx_041461_TRAP_NOP)
            MEM_trap = MEM_trap_in;
        else if (MEM_rd_en && !aligned)
            MEM_trap = ysyx_041461_MEM_LOAD_MISALIGN;
        else if (MEM_wr_en && !aligned)
            MEM_trap = ysyx_041461_MEM_STORE_MISALIGN;
    end

    assign access = MEM_valid & (MEM_rd_en | MEM_wr_en)
                  & (MEM_trap_in == ysyx_041461_TRAP_NOP) & aligned;

    always_comb begin
        base_mask = 8'h01;
        case (MEM_size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Load alignment uses the latched offset/size so the result stays correct
    // even though the bus address has its low bits cleared.
    assign raw = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = raw;
        case (size_q)
            2'd0:    load_ext = uns_q ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    load_ext = uns_q ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    load_ext = uns_q ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
            mem_wmask <= 8'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            off_q     <= 3'd0;
            result_q  <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        mem_addr  <= {MEM_addr[63:3], 3'b000};
                        mem_we    <= MEM_wr_en;
                        mem_wdata <= MEM_wdata << {MEM_addr[2:0], 3'b000};
                        mem_wmask <= base_mask << MEM_addr[2:0];
                        size_q    <= MEM_size;
                        uns_q     <= MEM_unsigned;
                        off_q     <= MEM_addr[2:0];
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (!mem_we)
                            result_q <= load_ext;
`ifdef YSYX_041461_MEM_ACK_BYPASS_EN
                        state <= WB_ready ? S_IDLE : S_DONE;
`else
                        state <= S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    if (WB_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req = (state == S_REQ);

    always_comb begin
        MEM_ok = 1'b0;
        case (state)
            S_IDLE: MEM_ok = ~access;
`ifdef YSYX_041461_MEM_ACK_BYPASS_EN
            S_REQ:  MEM_ok = mem_ack;
`else
            S_REQ:  MEM_ok = 1'b0;
`endif
            S_DONE: MEM_ok = 1'b1;
            default: MEM_ok = 1'b0;
        endcase
    end

`ifdef YSYX_041461_MEM_ACK_BYPASS_EN
    assign MEM_result = (mem_req && mem_ack && !mem_we) ? load_ext : result_q;
`else
    assign MEM_result = result_q;
`endif

    assign MEM_ready = MEM_ok & WB_ready;

endmodule

// File: tb/tb_ysyx_041461_mem.sv
// tb/tb_ysyx_041461_mem.sv - randomized self-checking bench for ysyx_041461_mem
module tb_ysyx_041461_mem;

    localparam logic [3:0] TRAP_NOP   = 4'd0;
    localparam logic [3:0] TRAP_LMIS  = 4'd4;
    localparam logic [3:0] TRAP_SMIS  = 4'd6;
    localparam logic [3:0] TRAP_ECALL = 4'd11;

    logic        clk;
    logic        rst;
    logic        MEM_valid, MEM_rd_en, MEM_wr_en, MEM_unsigned, WB_ready;
    logic [1:0]  MEM_size;
    logic [63:0] MEM_addr, MEM_wdata;
    logic [3:0]  MEM_trap_in;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic [63:0] MEM_result;
    logic [3:0]  MEM_trap;
    logic        MEM_ok, MEM_ready;

    ysyx_041461_mem dut (
        .clk(clk), .rst(rst),
        .MEM_valid(MEM_valid), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en),
        .MEM_size(MEM_size), .MEM_unsigned(MEM_unsigned),
        .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_trap_in(MEM_trap_in),
        .WB_ready(WB_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .MEM_result(MEM_result), .MEM_trap(MEM_trap),
        .MEM_ok(MEM_ok), .MEM_ready(MEM_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] model_res;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte-level view of a load: pick n bytes starting at the offset, then extend.
    function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off,
                                             input int size, input bit uns);
        logic [7:0]  b [8];
        logic [63:0] r;
        int n;
        n = 1 << size;
        for (int i = 0; i < 8; i++) b[i] = rd[8*i +: 8];
        r = 64'd0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) r[8*i +: 8] = b[off + i];
        if (!uns && n < 8 && r[8*n-1])
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [7:0] ref_mask(input int off, input int size);
        logic [7:0] m;
        m = 8'd0;
        for (int i = 0; i < (1 << size); i++)
            if (off + i < 8) m[off + i] = 1'b1;
        return m;
    endfunction

    // kind: 0 = non-memory, 1 = load, 2 = store
    task automatic run_op(input string nm, input int kind, input int size, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [3:0] tin, input int dly, input int stall,
                          input logic [63:0] rdata);
        int off;
        bit al, need;
        logic [3:0]  etrap;
        logic [63:0] eres;
        off  = int'(addr[2:0]);
        al   = (addr % (64'd1 << size)) == 64'd0;
        if (tin != TRAP_NOP)          etrap = tin;
        else if (kind == 1 && !al)    etrap = TRAP_LMIS;
        else if (kind == 2 && !al)    etrap = TRAP_SMIS;
        else                          etrap = TRAP_NOP;
        need = (kind != 0) && (tin == TRAP_NOP) && al;
        eres = ref_load(rdata, off, size, uns);

        MEM_valid    = 1'b1;
        MEM_rd_en    = (kind == 1);
        MEM_wr_en    = (kind == 2);
        MEM_size     = size[1:0];
        MEM_unsigned = uns;
        MEM_addr     = addr;
        MEM_wdata    = wdata;
        MEM_trap_in  = tin;
        WB_ready     = (stall == 0);
        #3;
        chk({nm, "/trap"}, MEM_trap, etrap);
        chk({nm, "/ok0"}, MEM_ok, need ? 0 : 1);
        chk({nm, "/req0"}, mem_req, 0);
        if (!need) begin
            chk({nm, "/ready0"}, MEM_ready, stall == 0);
            step();
            MEM_valid = 1'b0;
            #3;
            chk({nm, "/hold"}, MEM_result, model_res);
            chk({nm, "/noreq"}, mem_req, 0);
            step();
            return;
        end

        step();
        #3;
        chk({nm, "/req"}, mem_req, 1);
        chk({nm, "/addr"}, mem_addr, {addr[63:3], 3'b000});
        chk({nm, "/we"}, mem_we, kind == 2);
        if (kind == 2) begin
            chk({nm, "/wdata"}, mem_wdata, wdata << (8 * off));
            chk({nm, "/wmask"}, mem_wmask, ref_mask(off, size));
        end
        for (int d = 0; d < dly; d++) begin
            step();
            #3;
            chk({nm, "/req_wait"}, mem_req, 1);
            chk({nm, "/ok_wait"}, MEM_ok, 0);
            chk({nm, "/addr_wait"}, mem_addr, {addr[63:3], 3'b000});
        end
        step();
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        #3;
        chk({nm, "/req_ack"}, mem_req, 1);
`ifdef YSYX_041461_MEM_ACK_BYPASS_EN
        chk({nm, "/ok_ack"}, MEM_ok, 1);
        chk({nm, "/ready_ack"}, MEM_ready, stall == 0);
        if (kind == 1) chk({nm, "/res_ack"}, MEM_result, eres);
`else
        chk({nm, "/ok_ack"}, MEM_ok, 0);
`endif
        step();
        mem_ack   = 1'b0;
        mem_rdata = {$urandom(), $urandom()};
        if (kind == 1) model_res = eres;
`ifdef YSYX_041461_MEM_ACK_BYPASS_EN
        if (stall == 0) begin
            MEM_valid = 1'b0;
            #3;
            chk({nm, "/req_end"}, mem_req, 0);
            chk({nm, "/res_end"}, MEM_result, model_res);
            step();
            return;
        end
`endif
        for (int s = 0; s < stall; s++) begin
            WB_ready = 1'b0;
            #3;
            chk({nm, "/ok_stall"}, MEM_ok, 1);
            chk({nm, "/ready_stall"}, MEM_ready, 0);
            chk({nm, "/req_stall"}, mem_req, 0);
            chk({nm, "/res_stall"}, MEM_result, model_res);
            step();
        end
        WB_ready = 1'b1;
        #3;
        chk({nm, "/ok_done"}, MEM_ok, 1);
        chk({nm, "/ready_done"}, MEM_ready, 1);
        chk({nm, "/res_done"}, MEM_result, model_res);
        step();
        MEM_valid = 1'b0;
        WB_ready  = 1'b0;
        #3;
        chk({nm, "/req_end"}, mem_req, 0);
        chk({nm, "/res_end"}, MEM_result, model_res);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, size, dly, stall;
        bit uns;
        logic [63:0] addr;
        logic [3:0]  tin;

        rst = 1'b1;
        MEM_valid = 0; MEM_rd_en = 0; MEM_wr_en = 0; MEM_size = 0; MEM_unsigned = 0;
        MEM_addr = 0; MEM_wdata = 0; MEM_trap_in = TRAP_NOP; WB_ready = 0;
        mem_ack = 0; mem_rdata = 0;
        model_res = 64'd0;
        step();
        step();
        #3;
        chk("rst/req", mem_req, 0);
        chk("rst/we", mem_we, 0);
        chk("rst/addr", mem_addr, 0);
        chk("rst/wdata", mem_wdata, 0);
        chk("rst/wmask", mem_wmask, 0);
        chk("rst/result", MEM_result, 0);
        step();
        rst = 1'b0;

        run_op("lw", 1, 2, 0, 64'h80000004, 64'd0, TRAP_NOP, 0, 0, 64'h8765432100000000);
        run_op("sb", 2, 0, 0, 64'h80000003, 64'hAB, TRAP_NOP, 3, 0, 64'd0);
        run_op("sh_mis", 2, 1, 0, 64'h80000001, 64'h1234, TRAP_NOP, 0, 0, 64'd0);
        run_op("ld_mis", 1, 3, 0, 64'h80000004, 64'd0, TRAP_NOP, 0, 0, 64'd0);
        run_op("ecall", 1, 3, 0, 64'h80000000, 64'd0, TRAP_ECALL, 0, 0, 64'd0);
        run_op("lbu", 1, 0, 1, 64'h80000007, 64'd0, TRAP_NOP, 0, 4, 64'hF0123456789ABCDE);
        run_op("lb", 1, 0, 0, 64'h80000007, 64'd0, TRAP_NOP, 1, 1, 64'hF0123456789ABCDE);

        // Reset while the request is outstanding; a late ack must be ignored.
        MEM_valid = 1; MEM_rd_en = 1; MEM_wr_en = 0; MEM_size = 2'd3; MEM_unsigned = 0;
        MEM_addr = 64'h80000010; MEM_trap_in = TRAP_NOP; WB_ready = 1;
        step();
        #3;
        chk("rstreq/req_before", mem_req, 1);
        step();
        rst = 1'b1;
        MEM_valid = 0;
        step();
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 64'hDEADBEEF_CAFEF00D;
        #3;
        chk("rstreq/req_after", mem_req, 0);
        chk("rstreq/ok_idle", MEM_ok, 1);
        chk("rstreq/result", MEM_result, 0);
        step();
        mem_ack = 1'b0;
        #3;
        chk("rstreq/req_late", mem_req, 0);
        chk("rstreq/result_late", MEM_result, 0);
        model_res = 64'd0;
        step();

        for (int i = 0; i < 200; i++) begin
            kind  = $urandom_range(2, 0);
            size  = $urandom_range(3, 0);
            uns   = 1'($urandom_range(1, 0));
            addr  = {$urandom(), $urandom()};
            if ($urandom_range(3, 0) != 0)
                addr = addr & ~((64'd1 << size) - 64'd1);
            tin   = ($urandom_range(7, 0) == 0) ? TRAP_ECALL : TRAP_NOP;
            dly   = $urandom_range(3, 0);
            stall = $urandom_range(2, 0);
            run_op($sformatf("rnd%0d", i), kind, size, uns, addr,
                   {$urandom(), $urandom()}, tin, dly, stall, {$urandom(), $urandom()});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
